siggen_burst_trigger: RTL and testbench

Parametrised multi-channel trigger generator for the external signal generators. It produces a square trigger of programmable half-period on up to `NUM_CH` outputs, either as a burst of N pulses or continuously. A host endpoint-wire rising edge starts it; `abort` stops it. It replaces the fixed 40 Hz / 1000-pulse trigger and sits between the host endpoint wires and the siggen trigger pins.

---
 rtl/siggen_burst_trigger.sv | 151 +++++++++++++++
 tb/tb_siggen_burst_trigger.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/siggen_burst_trigger.sv
// Multi-channel square-wave trigger generator for the external signal generators.
// Emits a burst of N pulses or a continuous train of programmable half-period.
module siggen_burst_trigger #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 2
) (
  input  logic              clki,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] trig_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulses_done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic                start_dly_q;
  logic                phase_q, phase_d;
  logic                done_q, done_d;
  logic                cont_q, cont_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    pd_q, pd_d;
  logic [CNT_W-1:0]    hp_q, hp_d;
  logic [CNT_W-1:0]    pc_q, pc_d;
  logic [NUM_CH-1:0]   chen_q, chen_d;
  logic [NUM_CH-1:0]   trig_q, trig_d;

  logic             start_edge;
  logic             accept;
  logic             zero_burst;
  logic             go;
  logic             wrap;
  logic             fall;
  logic             last;
  logic [CNT_W-1:0] hp_in;
  logic [CNT_W-1:0] pd_inc;

  assign start_edge = start & ~start_dly_q;
  assign accept     = (state_q == IDLE) & start_edge & ~abort;
  assign zero_burst = accept & ~continuous & (pulse_count == '0);
  assign go         = accept & ~zero_burst;
  assign hp_in      = (half_period == '0) ? ONE : half_period;
  assign wrap       = (cnt_q == hp_q - ONE);
  assign fall       = wrap & phase_q;
  assign pd_inc     = pd_q + ONE;
  assign last       = fall & ~cont_q & (pd_inc == pc_q);

  // State and datapath registers
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      pd_q        <= '0;
      hp_q        <= ONE;
      pc_q        <= '0;
      chen_q      <= '0;
      trig_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start;
      phase_q     <= phase_d;
      done_q      <= done_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      pd_q        <= pd_d;
      hp_q        <= hp_d;
      pc_q        <= pc_d;
      chen_q      <= chen_d;
      trig_q      <= trig_d;
    end
  end

  // Next state: abort wins over a burst end in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: config latch, half-period counter, phase and pulse count
  always_comb begin
    phase_d = phase_q;
    done_d  = 1'b0;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    pd_d    = pd_q;
    hp_d    = hp_q;
    pc_d    = pc_q;
    chen_d  = chen_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pd_d   = '0;
          done_d = zero_burst;
        end
        if (go) begin
          hp_d    = hp_in;
          pc_d    = pulse_count;
          cont_d  = continuous;
          chen_d  = ch_en;
          phase_d = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          phase_d = 1'b0;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (fall) pd_d = pd_inc;
          if (last) done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: phase_d = 1'b0;
    endcase
  end

  // Registered outputs follow the next phase so trig_out is a clean flop
  always_comb begin
    trig_d = phase_d ? chen_d : '0;
  end

  assign trig_out    = trig_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign pulses_done = pd_q;

endmodule

// File: tb/tb_siggen_burst_trigger.sv
// Scoreboard bench for siggen_burst_trigger.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_siggen_burst_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [31:0] half_period;
  logic [31:0] pulse_count;
  logic [1:0]  ch_en;
  logic [1:0]  trig_out;
  logic        busy;
  logic        done;
  logic [31:0] pulses_done;

  typedef struct {
    int          tid;
    logic [1:0]  trig;
    logic        busy;
    logic        done;
    logic [31:0] pd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tid   = 0;

  siggen_burst_trigger #(.CNT_W(32), .NUM_CH(2)) dut (
    .clki       (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .half_period(half_period),
    .pulse_count(pulse_count),
    .ch_en      (ch_en),
    .trig_out   (trig_out),
    .busy       (busy),
    .done       (done),
    .pulses_done(pulses_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [1:0] t, input logic b,
                     input logic d, input logic [31:0] pd);
    exp_t e;
    e.tid  = tid;
    e.trig = t;
    e.busy = b;
    e.done = d;
    e.pd   = pd;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic seg(input int n, input logic [1:0] t, input logic b,
                     input logic d, input logic [31:0] pd);
    for (int i = 0; i < n; i++) cyc(t, b, d, pd);
  endtask

  task automatic check_now(input string nm);
    n_vec++;
    if (trig_out !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
        pulses_done !== 32'd0) begin
      n_bad++;
      $display("FAIL %s: got trig=%b busy=%b done=%b pd=%0d want all zero",
               nm, trig_out, busy, done, pulses_done);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (trig_out !== e.trig || busy !== e.busy ||
            done !== e.done || pulses_done !== e.pd) begin
          n_bad++;
          $display("FAIL test%0d cyc: got trig=%b busy=%b done=%b pd=%0d want trig=%b busy=%b done=%b pd=%0d",
                   e.tid, trig_out, busy, done, pulses_done,
                   e.trig, e.busy, e.done, e.pd);
        end
      end
    end
  end

  initial begin : stim
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    continuous  = 1'b0;
    half_period = 32'd4;
    pulse_count = 32'd3;
    ch_en       = 2'b11;
    #1;
    check_now("reset_state");
    @(negedge clk);
    seg(2, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    seg(2, 2'b00, 0, 0, 0);

    // zero-count burst
    tid = 1;
    pulse_count = 32'd0;
    start = 1'b1;
    seg(1, 2'b00, 0, 1, 0);
    start = 1'b0;
    seg(2, 2'b00, 0, 0, 0);

    // basic burst H=4 x3
    tid = 2;
    half_period = 32'd4;
    pulse_count = 32'd3;
    ch_en = 2'b11;
    start = 1'b1;
    seg(4, 2'b11, 1, 0, 0);
    start = 1'b0;
    seg(4, 2'b00, 1, 0, 1);
    seg(4, 2'b11, 1, 0, 1);
    seg(4, 2'b00, 1, 0, 2);
    seg(4, 2'b11, 1, 0, 2);
    seg(1, 2'b00, 0, 1, 3);
    seg(2, 2'b00, 0, 0, 3);

    // H=0 treated as 1, only ch1 enabled
    tid = 3;
    half_period = 32'd0;
    pulse_count = 32'd2;
    ch_en = 2'b10;
    start = 1'b1;
    seg(1, 2'b10, 1, 0, 0);
    start = 1'b0;
    seg(1, 2'b00, 1, 0, 1);
    seg(1, 2'b10, 1, 0, 1);
    seg(1, 2'b00, 0, 1, 2);
    seg(2, 2'b00, 0, 0, 2);

    // continuous H=5, start re-toggled in RUN, then abort
    tid = 4;
    half_period = 32'd5;
    pulse_count = 32'd2;
    continuous = 1'b1;
    ch_en = 2'b11;
    start = 1'b1;
    seg(5, 2'b11, 1, 0, 0);
    start = 1'b0;
    seg(5, 2'b00, 1, 0, 1);
    start = 1'b1;
    seg(5, 2'b11, 1, 0, 1);
    start = 1'b0;
    seg(5, 2'b00, 1, 0, 2);
    seg(5, 2'b11, 1, 0, 2);
    seg(5, 2'b00, 1, 0, 3);
    seg(4, 2'b11, 1, 0, 3);
    abort = 1'b1;
    seg(1, 2'b00, 0, 0, 3);
    abort = 1'b0;
    continuous = 1'b0;
    seg(2, 2'b00, 0, 0, 3);

    // abort with a start edge in IDLE; held start is not an edge
    tid = 5;
    abort = 1'b1;
    start = 1'b1;
    seg(1, 2'b00, 0, 0, 3);
    abort = 1'b0;
    seg(1, 2'b00, 0, 0, 3);
    start = 1'b0;
    seg(1, 2'b00, 0, 0, 3);

    // async reset during 2nd high phase
    tid = 6;
    half_period = 32'd3;
    pulse_count = 32'd10;
    ch_en = 2'b11;
    start = 1'b1;
    seg(1, 2'b11, 1, 0, 0);
    start = 1'b0;
    seg(2, 2'b11, 1, 0, 0);
    seg(3, 2'b00, 1, 0, 1);
    seg(2, 2'b11, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset");
    seg(2, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    seg(3, 2'b00, 0, 0, 0);
    pulse_count = 32'd2;
    start = 1'b1;
    seg(3, 2'b11, 1, 0, 0);
    start = 1'b0;
    seg(3, 2'b00, 1, 0, 1);
    seg(3, 2'b11, 1, 0, 1);
    seg(1, 2'b00, 0, 1, 2);
    seg(1, 2'b00, 0, 0, 2);

    // config change in RUN has no effect until next start
    tid = 7;
    half_period = 32'd4;
    pulse_count = 32'd2;
    ch_en = 2'b11;
    start = 1'b1;
    seg(1, 2'b11, 1, 0, 0);
    start = 1'b0;
    half_period = 32'd9;
    ch_en = 2'b01;
    seg(3, 2'b11, 1, 0, 0);
    seg(4, 2'b00, 1, 0, 1);
    seg(4, 2'b11, 1, 0, 1);
    seg(1, 2'b00, 0, 1, 2);
    seg(1, 2'b00, 0, 0, 2);
    tid = 8;
    start = 1'b1;
    seg(1, 2'b01, 1, 0, 0);
    start = 1'b0;
    seg(8, 2'b01, 1, 0, 0);
    seg(9, 2'b00, 1, 0, 1);
    seg(9, 2'b01, 1, 0, 1);
    seg(1, 2'b00, 0, 1, 2);
    seg(2, 2'b00, 0, 0, 2);

    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
